// File: rtl/sc_regserializer_pkg.sv
// ---------------------------------------------------------------------------
// sc_regserializer_pkg
// Shared definitions for the register serializer slice:
//   - state encodings for the serializer FSM (IDLE/SHIFT/DONE)
//   - state enum built from those encodings
//   - scClog2: elaboration-time ceil(log2) used to size the bit counter
// ---------------------------------------------------------------------------
package sc_regserializer_pkg;

    localparam logic [1:0] SC_REGSERIALIZER_IDLE  = 2'b00;
    localparam logic [1:0] SC_REGSERIALIZER_SHIFT = 2'b01;
    localparam logic [1:0] SC_REGSERIALIZER_DONE  = 2'b10;

    typedef enum logic [1:0] {
        stIdle  = SC_REGSERIALIZER_IDLE,
        stShift = SC_REGSERIALIZER_SHIFT,
        stDone  = SC_REGSERIALIZER_DONE
    } regSerState_t;

    // ceil(log2(value)); value >= 2 is assumed by all callers.
    function automatic int scClog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_bitcounter.sv
// ---------------------------------------------------------------------------
// sc_bitcounter
// Bit position counter for the serializer. Clears to zero, increments on
// enable, and saturates at COUNTER_TERMINAL so it never wraps.
// Ports:
//   SC_REGGENERAL_CLOCK_50      in   clock, rising edge
//   SC_REGGENERAL_RESET_InHigh  in   async active-high reset
//   SC_BITCOUNTER_clear         in   synchronous clear (wins over enable)
//   SC_BITCOUNTER_enable        in   count one bit
//   SC_BITCOUNTER_terminal      out  count == COUNTER_TERMINAL
// ---------------------------------------------------------------------------
module sc_bitcounter #(
    parameter int                       COUNTER_WIDTH    = 3,
    parameter logic [COUNTER_WIDTH-1:0] COUNTER_TERMINAL = '1
) (
    input  logic SC_REGGENERAL_CLOCK_50,
    input  logic SC_REGGENERAL_RESET_InHigh,
    input  logic SC_BITCOUNTER_clear,
    input  logic SC_BITCOUNTER_enable,
    output logic SC_BITCOUNTER_terminal
);

    logic [COUNTER_WIDTH-1:0] bitCount;

    assign SC_BITCOUNTER_terminal = (bitCount == COUNTER_TERMINAL);

    // Hold at terminal: the FSM leaves SHIFT on that same edge, and the
    // count is cleared again in IDLE before the next word.
    always_ff @(posedge SC_REGGENERAL_CLOCK_50 or posedge SC_REGGENERAL_RESET_InHigh) begin
        if (SC_REGGENERAL_RESET_InHigh) begin
            bitCount <= '0;
        end else if (SC_BITCOUNTER_clear) begin
            bitCount <= '0;
        end else if (SC_BITCOUNTER_enable && !SC_BITCOUNTER_terminal) begin
            bitCount <= bitCount + 1'b1;
        end
    end

endmodule

// File: rtl/sc_regserializer.sv
// ---------------------------------------------------------------------------
// sc_regserializer
// Parallel-to-serial converter, MSB first, with a ready/valid style sink
// handshake. A word is captured from IDLE on an active-low load, shifted out
// one bit per accepted cycle, then a one-cycle DONE pulse is emitted.
// Ports:
//   SC_REGGENERAL_CLOCK_50        in   clock, rising edge
//   SC_REGGENERAL_RESET_InHigh    in   async active-high reset
//   SC_REGSERIALIZER_load_InLow   in   start request (active low)
//   SC_REGSERIALIZER_data_InBus   in   word to transmit
//   SC_REGSERIALIZER_ready_InHigh in   sink accepts current bit
//   SC_REGSERIALIZER_serial_Out   out  current bit (register MSB)
//   SC_REGSERIALIZER_valid_Out    out  serial bit is valid
//   SC_REGSERIALIZER_busy_Out     out  word in flight (SHIFT or DONE)
//   SC_REGSERIALIZER_done_Out     out  one-cycle pulse after last bit
// ---------------------------------------------------------------------------
module sc_regserializer
    import sc_regserializer_pkg::*;
#(
    parameter int REGSERIALIZER_DATAWIDTH = 32
) (
    input  logic                               SC_REGGENERAL_CLOCK_50,
    input  logic                               SC_REGGENERAL_RESET_InHigh,
    input  logic                               SC_REGSERIALIZER_load_InLow,
    input  logic [REGSERIALIZER_DATAWIDTH-1:0] SC_REGSERIALIZER_data_InBus,
    input  logic                               SC_REGSERIALIZER_ready_InHigh,
    output logic                               SC_REGSERIALIZER_serial_Out,
    output logic                               SC_REGSERIALIZER_valid_Out,
    output logic                               SC_REGSERIALIZER_busy_Out,
    output logic                               SC_REGSERIALIZER_done_Out
);

    localparam int                  CNT_W    = scClog2(REGSERIALIZER_DATAWIDTH);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(REGSERIALIZER_DATAWIDTH - 1);

    regSerState_t                       state;
    regSerState_t                       stateNext;
    logic [REGSERIALIZER_DATAWIDTH-1:0] shiftReg;
    logic                               counterClear;
    logic                               counterEnable;
    logic                               lastBit;
    logic                               captureWord;
    logic                               bitAccepted;

    assign captureWord   = (state == stIdle)  && !SC_REGSERIALIZER_load_InLow;
    assign bitAccepted   = (state == stShift) &&  SC_REGSERIALIZER_ready_InHigh;
    // Clearing throughout IDLE guarantees a zero count on the first SHIFT cycle.
    assign counterClear  = (state == stIdle);
    assign counterEnable = bitAccepted;

    sc_bitcounter #(
        .COUNTER_WIDTH    (CNT_W),
        .COUNTER_TERMINAL (LAST_BIT)
    ) bitCounter (
        .SC_REGGENERAL_CLOCK_50     (SC_REGGENERAL_CLOCK_50),
        .SC_REGGENERAL_RESET_InHigh (SC_REGGENERAL_RESET_InHigh),
        .SC_BITCOUNTER_clear        (counterClear),
        .SC_BITCOUNTER_enable       (counterEnable),
        .SC_BITCOUNTER_terminal     (lastBit)
    );

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            stIdle:  if (!SC_REGSERIALIZER_load_InLow) stateNext = stShift;
            stShift: if (SC_REGSERIALIZER_ready_InHigh && lastBit) stateNext = stDone;
            stDone:  stateNext = stIdle;
            default: stateNext = stIdle;
        endcase
    end

    // State register
    always_ff @(posedge SC_REGGENERAL_CLOCK_50 or posedge SC_REGGENERAL_RESET_InHigh) begin
        if (SC_REGGENERAL_RESET_InHigh) begin
            state <= stIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Shift register: load only from IDLE so a load during a transfer
    // cannot disturb the word in flight.
    always_ff @(posedge SC_REGGENERAL_CLOCK_50 or posedge SC_REGGENERAL_RESET_InHigh) begin
        if (SC_REGGENERAL_RESET_InHigh) begin
            shiftReg <= '0;
        end else if (captureWord) begin
            shiftReg <= SC_REGSERIALIZER_data_InBus;
        end else if (bitAccepted) begin
            shiftReg <= {shiftReg[REGSERIALIZER_DATAWIDTH-2:0], 1'b0};
        end
    end

    // Output logic: decoded straight from state so reset clears outputs
    // without waiting for an edge.
    always_comb begin
        SC_REGSERIALIZER_serial_Out = 1'b0;
        SC_REGSERIALIZER_valid_Out  = 1'b0;
        SC_REGSERIALIZER_busy_Out   = 1'b0;
        SC_REGSERIALIZER_done_Out   = 1'b0;
        case (state)
            stShift: begin
                SC_REGSERIALIZER_serial_Out = shiftReg[REGSERIALIZER_DATAWIDTH-1];
                SC_REGSERIALIZER_valid_Out  = 1'b1;
                SC_REGSERIALIZER_busy_Out   = 1'b1;
            end
            stDone: begin
                SC_REGSERIALIZER_busy_Out   = 1'b1;
                SC_REGSERIALIZER_done_Out   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sc_regserializer.sv
// ---------------------------------------------------------------------------
// tb_sc_regserializer
// Self-checking bench for sc_regserializer at width 8. A queue-based model
// predicts the outputs every cycle; directed scenarios additionally pin
// bitstreams and done timing to hand-computed values, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_sc_regserializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] data;
    logic         ready;
    logic         serial;
    logic         valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sc_regserializer #(.REGSERIALIZER_DATAWIDTH(W)) dut (
        .SC_REGGENERAL_CLOCK_50        (clk),
        .SC_REGGENERAL_RESET_InHigh    (rst),
        .SC_REGSERIALIZER_load_InLow   (load),
        .SC_REGSERIALIZER_data_InBus   (data),
        .SC_REGSERIALIZER_ready_InHigh (ready),
        .SC_REGSERIALIZER_serial_Out   (serial),
        .SC_REGSERIALIZER_valid_Out    (valid),
        .SC_REGSERIALIZER_busy_Out     (busy),
        .SC_REGSERIALIZER_done_Out     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the bits still owed to the sink, plus a flag for the done cycle.
    bit mq[$];
    bit mDone;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mDone = 1'b0;
        end else if (mq.size() > 0) begin
            if (ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) mDone = 1'b1;
            end
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (!load) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back(data[i]);
        end
    end

    // Observation log used by the directed scenarios.
    logic [31:0] accBits;
    int          accCnt;
    int          doneCnt;
    int          doneLog [0:3];

    task automatic clearLog();
        accBits = '0;
        accCnt  = 0;
        doneCnt = 0;
        for (int i = 0; i < 4; i++) doneLog[i] = -1;
    endtask

    always @(negedge clk) begin
        logic [3:0] expv;
        expv[3] = (mq.size() > 0);
        expv[2] = (mq.size() > 0) || mDone;
        expv[1] = mDone;
        expv[0] = (mq.size() > 0) ? mq[0] : 1'b0;
        chk("valid/busy/done/serial", {28'd0, valid, busy, done, serial}, {28'd0, expv});
        if (!rst) begin
            if (valid && ready) begin
                accBits = {accBits[30:0], serial};
                accCnt++;
            end
            if (done) begin
                if (doneCnt < 4) doneLog[doneCnt] = cyc;
                doneCnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int L;

    initial begin
        rst   = 1'b1;
        load  = 1'b1;
        data  = '0;
        ready = 1'b1;
        clearLog();
        #2;
        chk("reset outputs", {28'd0, valid, busy, done, serial}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // A5, ready tied high
        clearLog();
        load = 1'b0; data = 8'hA5;
        tick(); L = cyc;
        load = 1'b1;
        repeat (10) tick();
        chk("A5 bits", accBits, 32'h000000A5);
        chk("A5 count", accCnt, 8);
        chk("A5 done count", doneCnt, 1);
        chk("A5 done latency", doneLog[0] - L, 8);

        // F0, ready toggling starting high
        clearLog();
        load = 1'b0; data = 8'hF0; ready = 1'b1;
        tick(); L = cyc;
        load = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            tick();
            ready = (j % 2 == 0);
        end
        ready = 1'b1;
        chk("F0 bits", accBits, 32'h000000F0);
        chk("F0 count", accCnt, 8);
        chk("F0 done count", doneCnt, 1);
        chk("F0 done latency", doneLog[0] - L, 15);

        // 3C with a load pulse carrying FF during bit 3
        clearLog();
        load = 1'b0; data = 8'h3C;
        tick();
        load = 1'b1;
        repeat (3) tick();
        load = 1'b0; data = 8'hFF;
        tick();
        load = 1'b1; data = 8'h3C;
        repeat (10) tick();
        chk("3C bits", accBits, 32'h0000003C);
        chk("3C count", accCnt, 8);
        chk("3C done count", doneCnt, 1);

        // 81 aborted by reset after bit 4
        clearLog();
        load = 1'b0; data = 8'h81;
        tick();
        load = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("abort outputs", {28'd0, valid, busy, done, serial}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort bits", accBits, 32'h00000008);
        chk("abort count", accCnt, 4);
        chk("abort no done", doneCnt, 0);

        // 55 after the abort
        clearLog();
        load = 1'b0; data = 8'h55;
        tick(); L = cyc;
        load = 1'b1;
        repeat (10) tick();
        chk("55 bits", accBits, 32'h00000055);
        chk("55 done latency", doneLog[0] - L, 8);

        // 01 then 80 with load held low
        clearLog();
        load = 1'b0; data = 8'h01;
        tick(); L = cyc;
        data = 8'h80;
        repeat (10) tick();
        load = 1'b1;
        repeat (12) tick();
        chk("b2b bits", accBits, 32'h00000180);
        chk("b2b count", accCnt, 16);
        chk("b2b done count", doneCnt, 2);
        chk("b2b first done", doneLog[0] - L, 8);
        chk("b2b spacing", doneLog[1] - doneLog[0], 10);

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int n = 0; n < 2000; n++) begin
            load  = ($urandom_range(0, 3) != 0);
            data  = W'($urandom);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        load = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
